dense_out_drain: RTL and testbench

//  Downstream stage of the dense sequencer. Each dense_latch pulse carries a PE count and an output-block index.
//  Per request, walks the PE-array dense latch select (rd_addr) over PEs 0..cnt-1.

---
 rtl/dense_pkg.sv | 11 +
 rtl/dense_req_fifo.sv | 46 ++++
 rtl/dense_out_drain.sv | 100 ++++++++++
 tb/tb_dense_out_drain.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// dense_pkg: constants and request/state types shared by the dense sequencer and its output drain.
package dense_pkg;
    localparam int N_PE         = 8;
    localparam int LOG_N_PE     = 3;
    localparam int DENSE_PER_GO = N_PE;
    typedef enum logic [1:0] {IDLE, READ, FLUSH} drain_state_e;
    typedef struct packed {
        logic [LOG_N_PE:0] cnt;
        logic [15:0]       blk;
    } dense_req_t;
endpackage

// File: rtl/dense_req_fifo.sv
// dense_req_fifo: small sync FIFO of pending dense requests.
// A push into a full FIFO is accepted when a pop happens in the same cycle; clear wins over pop but not over push.
module dense_req_fifo
    import dense_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  dense_req_t din_i,
    output dense_req_t dout_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int PW = $clog2(DEPTH);
    dense_req_t mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, wr_idx;
    logic [PW:0] cnt_q, cnt_d;
    logic do_pop, do_push;
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rp_q];
    assign do_pop  = pop_i && !empty_o && !clr_i;
    assign do_push = push_i && (!full_o || do_pop || clr_i);
    assign wr_idx  = clr_i ? '0 : wp_q;
    assign wp_d    = wr_idx + PW'(do_push);
    assign rp_d    = clr_i ? '0 : rp_q + PW'(do_pop);
    assign cnt_d   = clr_i ? (PW+1)'(do_push) : cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx] <= din_i;
    end
endmodule

// File: rtl/dense_out_drain.sv
// dense_out_drain: walks PE dense latches for each queued request and writes neurons to blk*N_PE+pe.
// Reads are issued from registered state; writes trail reads by one cycle.
module dense_out_drain
    import dense_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int REQ_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                layer_start,
    input  logic                latch_i,
    input  logic [LOG_N_PE:0]   latch_cnt_i,
    input  logic [15:0]         latch_blk_i,
    output logic                rd_en_o,
    output logic [LOG_N_PE-1:0] rd_addr_o,
    input  logic [DATA_W-1:0]   rd_data_i,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [DATA_W-1:0]   wr_data_o,
    output logic                busy_o,
    output logic                q_full_o,
    output logic                drained_o,
    output logic                overflow_o,
    output logic                bad_cnt_o
);
    localparam int CW = LOG_N_PE + 1;
    drain_state_e state_q, state_d;
    logic [LOG_N_PE-1:0] idx_q, idx_d;
    dense_req_t cur_q, cur_d, q_head, lat_req;
    logic legal, last, start_ok, q_empty, pop, bypass, push, drop;
    logic wr_en_q, drained_q, overflow_q, bad_q;
    logic [ADDR_W-1:0] wr_addr_q;
    assign lat_req  = '{cnt: latch_cnt_i, blk: latch_blk_i};
    assign legal    = latch_cnt_i != '0 && latch_cnt_i <= CW'(N_PE);
    assign last     = {1'b0, idx_q} == cur_q.cnt - CW'(1);
    assign start_ok = state_q != READ || last;
    assign pop      = start_ok && !q_empty && !layer_start;
    // An idle engine takes a fresh latch directly instead of routing it through the queue
    assign bypass   = state_q != READ && (q_empty || layer_start) && latch_i && legal;
    assign push     = latch_i && legal && !bypass;
    assign drop     = push && q_full_o && !pop && !layer_start;
    dense_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (layer_start),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (lat_req),
        .dout_o  (q_head),
        .full_o  (q_full_o),
        .empty_o (q_empty)
    );
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        if (pop || bypass) begin
            state_d = READ;
            idx_d   = '0;
            cur_d   = pop ? q_head : lat_req;
        end else if (state_q == READ) begin
            state_d = last ? FLUSH : READ;
            idx_d   = idx_q + LOG_N_PE'(1);
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cur_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            drained_q  <= 1'b0;
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_q      <= cur_d;
            wr_en_q    <= rd_en_o;
            wr_addr_q  <= rd_en_o ? ADDR_W'(32'(cur_q.blk) * N_PE + 32'(idx_q)) : wr_addr_q;
            drained_q  <= rd_en_o && last;
            overflow_q <= !layer_start && (overflow_q || drop);
            bad_q      <= (bad_q && !layer_start) || (latch_i && !legal);
        end
    end
    assign rd_en_o    = state_q == READ;
    assign rd_addr_o  = idx_q;
    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_en_q ? rd_data_i : '0;
    assign drained_o  = drained_q;
    assign busy_o     = state_q != IDLE || !q_empty;
    assign overflow_o = overflow_q;
    assign bad_cnt_o  = bad_q;
endmodule

// File: tb/tb_dense_out_drain.sv
// tb_dense_out_drain: random and directed stimulus checked against a request-timeline model.
module tb_dense_out_drain;
    import dense_pkg::*;
    localparam int REQ_DEPTH = 2;
    typedef struct {
        int t;
        int s;
        int cnt;
        int blk;
    } req_t;
    logic clk = 1'b0, rst = 1'b1, layer_start = 1'b0, latch_i = 1'b0;
    logic [3:0] latch_cnt_i = '0;
    logic [15:0] latch_blk_i = '0;
    logic rd_en_o, wr_en_o, busy_o, q_full_o, drained_o, overflow_o, bad_cnt_o;
    logic [2:0] rd_addr_o;
    logic [15:0] rd_data_i = '0, wr_addr_o, wr_data_o;
    int n_chk = 0, n_fail = 0, cyc = 0;
    req_t reqs[$];
    bit ovf_m = 0, bad_m = 0;

    dense_out_drain dut (
        .clk(clk), .rst(rst), .layer_start(layer_start), .latch_i(latch_i),
        .latch_cnt_i(latch_cnt_i), .latch_blk_i(latch_blk_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .q_full_o(q_full_o), .drained_o(drained_o),
        .overflow_o(overflow_o), .bad_cnt_o(bad_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_data(input int c, input int pe);
        return {3'(pe), 13'(c)};
    endfunction

    // PE array stand-in: data is a function of the read cycle and PE index
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_data_i <= rd_en_o ? exp_data(cyc, int'(rd_addr_o)) : '0;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit queued(input req_t r, input int c);
        return r.s != r.t + 1 && r.t < c && r.s - 1 >= c;
    endfunction

    task automatic check_cycle(input int c);
        bit erd, ewr, edr, ebusy;
        int epe, wpe, waddr, qn;
        erd = 0; ewr = 0; edr = 0; ebusy = 0; epe = 0; wpe = 0; waddr = 0; qn = 0;
        foreach (reqs[i]) begin
            if (c >= reqs[i].s && c < reqs[i].s + reqs[i].cnt) begin
                erd = 1;
                epe = c - reqs[i].s;
            end
            if (c - 1 >= reqs[i].s && c - 1 < reqs[i].s + reqs[i].cnt) begin
                ewr = 1;
                wpe = c - 1 - reqs[i].s;
                waddr = (reqs[i].blk * N_PE + wpe) & 16'hffff;
                edr = wpe == reqs[i].cnt - 1;
            end
            if (reqs[i].t < c && c <= reqs[i].s + reqs[i].cnt) ebusy = 1;
            if (queued(reqs[i], c)) qn++;
        end
        check("rd_en", rd_en_o, erd);
        if (erd) check("rd_addr", rd_addr_o, epe);
        check("wr_en", wr_en_o, ewr);
        if (ewr) begin
            check("wr_addr", wr_addr_o, waddr);
            check("wr_data", wr_data_o, exp_data(c - 1, wpe));
        end
        check("drained", drained_o, edr);
        check("busy", busy_o, ebusy);
        check("q_full", q_full_o, qn == REQ_DEPTH);
        check("overflow", overflow_o, ovf_m);
        check("bad_cnt", bad_cnt_o, bad_m);
    endtask

    task automatic step(input bit lat, input int cnt, input int blk, input bit ls);
        int c, qn, e, s;
        bit popc;
        @(negedge clk);
        c = cyc;
        check_cycle(c);
        qn = 0; popc = 0; e = -100;
        foreach (reqs[i]) if (queued(reqs[i], c)) begin
            qn++;
            if (reqs[i].s - 1 == c) popc = 1;
        end
        if (ls) begin
            ovf_m = 0;
            bad_m = 0;
        end
        for (int i = reqs.size() - 1; i >= 0; i--)
            if ((ls && queued(reqs[i], c)) || reqs[i].s + reqs[i].cnt + 2 < c) reqs.delete(i);
        foreach (reqs[i]) if (reqs[i].s + reqs[i].cnt - 1 > e) e = reqs[i].s + reqs[i].cnt - 1;
        if (lat) begin
            if (cnt < 1 || cnt > N_PE) bad_m = 1;
            else if (!ls && qn == REQ_DEPTH && !popc) ovf_m = 1;
            else begin
                s = (c < e) ? e + 1 : (c == e) ? c + 2 : c + 1;
                reqs.push_back('{c, s, cnt, blk});
            end
        end
        latch_i = lat;
        latch_cnt_i = 4'(cnt);
        latch_blk_i = 16'(blk);
        layer_start = ls;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rd_en", rd_en_o, 0);
        check("rst_wr_en", wr_en_o, 0);
        check("rst_wr_addr", wr_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_bad", bad_cnt_o, 0);
        rst = 1'b0;
        step(1, 8, 3, 0); idle(12);
        step(1, 5, 2, 0); step(0, 0, 0, 0); step(1, 8, 3, 0); idle(18);
        step(1, 1, 0, 0); idle(5);
        step(1, 8, 5, 0); step(1, 2, 6, 0); step(1, 3, 7, 0); step(1, 4, 8, 0); idle(25);
        check("ovf_sticky", overflow_o, 1);
        step(0, 0, 0, 1); idle(3);
        step(1, 0, 9, 0); step(1, 9, 9, 0); idle(3);
        check("bad_sticky", bad_cnt_o, 1);
        step(1, 3, 4, 1); idle(6);
        step(1, 8, 1, 0); step(1, 4, 2, 0); step(1, 4, 3, 0); step(0, 0, 0, 1); idle(15);
        step(1, 8, 7, 0); idle(3);
        #1 rst = 1'b1;
        #1;
        check("arst_rd_en", rd_en_o, 0);
        check("arst_wr_en", wr_en_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_rd_addr", rd_addr_o, 0);
        @(negedge clk);
        rst = 1'b0;
        reqs.delete();
        ovf_m = 0;
        bad_m = 0;
        step(1, 4, 1, 0); idle(8);
        repeat (600) begin
            bit lat, ls;
            int cnt;
            lat = $urandom_range(0, 9) < 4;
            cnt = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 0 : 9) : $urandom_range(1, 8);
            ls = $urandom_range(0, 49) == 0;
            step(lat, cnt, $urandom_range(0, 16'hffff), ls);
        end
        idle(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
